// File: rtl/eth_port_ctrl_pkg.sv
// Shared definitions for the Ethernet port control register block:
// register offsets, ID constant, loopback mode encoding and AXI response codes.
package eth_port_ctrl_pkg;

  localparam logic [31:0] REG_ID       = 32'h00;
  localparam logic [31:0] REG_RST_TRIG = 32'h04;
  localparam logic [31:0] REG_LB_MODE  = 32'h08;
  localparam logic [31:0] REG_RST_WID  = 32'h0C;
  localparam logic [31:0] REG_STATUS   = 32'h10;
  localparam logic [31:0] REG_LINK_CHG = 32'h14;

  // Upper 24 bits of the ID register; the low byte carries the port count.
  localparam logic [23:0] ID_PREFIX = {16'hE796, 8'h01};

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    LB_NONE  = 2'b00,
    LB_LINE  = 2'b01,
    LB_LOCAL = 2'b10
  } lb_mode_t;

  // Word-aligned and inside the implemented register window.
  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr <= REG_LINK_CHG);
  endfunction

  // The reserved encoding 2'b11 collapses to normal operation.
  function automatic lb_mode_t lb_sanitize(input logic [1:0] field);
    lb_mode_t m;
    case (field)
      2'b01:   m = LB_LINE;
      2'b10:   m = LB_LOCAL;
      default: m = LB_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/eth_port_rst_gen.sv
// Per-port timed reset pulse generator. A trigger (re)loads the counter with
// the programmed width; reset_n stays low for exactly that many cycles after
// the trigger cycle. Comes out of arstn already running a default-width pulse.
module eth_port_rst_gen #(
  parameter int RST_CNT_WIDTH  = 16,
  parameter int RST_DEF_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trig,
  input  logic [RST_CNT_WIDTH-1:0] width,
  output logic                     reset_n,
  output logic                     busy
);

  logic [RST_CNT_WIDTH-1:0] cnt;

  // Countdown: trigger restarts the full width, busy drops after the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b1;
      cnt  <= RST_CNT_WIDTH'(RST_DEF_CYCLES);
    end else if (trig) begin
      busy <= 1'b1;
      cnt  <= width;
    end else if (busy) begin
      if (cnt <= RST_CNT_WIDTH'(1)) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - RST_CNT_WIDTH'(1);
      end
    end
  end

  assign reset_n = ~busy;

endmodule

// File: rtl/eth_port_ctrl.sv
// AXI4-Lite register block for per-port reset pulses, loopback select and
// link status of NUM_PORTS SGMII ports.
// Optional feature macro: ETH_PORT_CTRL_LINK_IRQ_EN enables sticky link-change
// flags (LINK_CHG) and the irq output; without it LINK_CHG reads 0 and irq is 0.
module eth_port_ctrl
  import eth_port_ctrl_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int RST_MIN_CYCLES = 16,
  parameter int RST_CNT_WIDTH  = 16,
  parameter int RST_DEF_CYCLES = 64
) (
  input  logic                   aclk,
  input  logic                   arstn,
  input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [31:0]            s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [31:0]            s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [NUM_PORTS-1:0]   port_reset_n,
  output logic [2*NUM_PORTS-1:0] lb_mode,
  input  logic [NUM_PORTS-1:0]   link_up,
  output logic                   irq
);

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [RST_CNT_WIDTH-1:0] clamp_width(input logic [RST_CNT_WIDTH-1:0] w);
    return (w < RST_CNT_WIDTH'(RST_MIN_CYCLES)) ? RST_CNT_WIDTH'(RST_MIN_CYCLES) : w;
  endfunction

  logic [2*NUM_PORTS-1:0]   lb_reg, lb_next;
  logic [RST_CNT_WIDTH-1:0] rst_width, wid_next;
  logic [NUM_PORTS-1:0]     trig, busy, chg_clr;
  logic [NUM_PORTS-1:0]     link_meta, link_sync, link_chg;
  logic [31:0]              wa, ra, lb_merged, wid_merged, set_mask, rd_val;
  logic                     wr_en, wr_ok, rd_en;
  lb_mode_t                 fld;

  // Write handshake: address and data accepted together, one response outstanding.
  assign wr_en         = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
  assign s_axi_awready = wr_en;
  assign s_axi_wready  = wr_en;
  assign wa            = 32'(s_axi_awaddr);
  assign wr_ok         = addr_ok(wa);

  assign lb_merged  = merge_strb(32'(lb_reg), s_axi_wdata, s_axi_wstrb);
  assign wid_merged = merge_strb(32'(rst_width), s_axi_wdata, s_axi_wstrb);
  assign set_mask   = merge_strb(32'h0, s_axi_wdata, s_axi_wstrb);

  // Bits beyond the configured ports / counter width are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{lb_merged, wid_merged, set_mask, chg_clr};

  // Register write decode: next values, reset triggers and W1C mask.
  always_comb begin
    lb_next  = lb_reg;
    wid_next = rst_width;
    trig     = '0;
    chg_clr  = '0;
    fld      = LB_NONE;
    if (wr_en && wr_ok) begin
      case (wa)
        REG_RST_TRIG: trig = set_mask[NUM_PORTS-1:0];
        REG_LB_MODE: begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            fld = lb_sanitize(lb_merged[2*p +: 2]);
            lb_next[2*p +: 2] = fld;
            if (fld != lb_reg[2*p +: 2]) trig[p] = 1'b1;
          end
        end
        REG_RST_WID:  wid_next = clamp_width(wid_merged[RST_CNT_WIDTH-1:0]);
        REG_LINK_CHG: chg_clr = set_mask[NUM_PORTS-1:0];
        default: ;
      endcase
    end
  end

  // Configuration registers; lb_mode moves on the same edge the reset pulse starts.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      lb_reg    <= '0;
      rst_width <= RST_CNT_WIDTH'(RST_DEF_CYCLES);
    end else begin
      lb_reg    <= lb_next;
      rst_width <= wid_next;
    end
  end

  assign lb_mode = lb_reg;

  // Write response channel: held until the master takes it.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else if (wr_en) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end

  assign rd_en         = s_axi_arvalid & ~s_axi_rvalid;
  assign s_axi_arready = rd_en;
  assign ra            = 32'(s_axi_araddr);

  // Read data mux over current register contents.
  always_comb begin
    rd_val = '0;
    case (ra)
      REG_ID:       rd_val = {ID_PREFIX, 8'(NUM_PORTS)};
      REG_RST_TRIG: rd_val = 32'(busy);
      REG_LB_MODE:  rd_val = 32'(lb_reg);
      REG_RST_WID:  rd_val = 32'(rst_width);
      REG_STATUS:   rd_val = {16'(busy), 16'(link_sync)};
      REG_LINK_CHG: rd_val = 32'(link_chg);
      default:      rd_val = '0;
    endcase
  end

  // Read data channel: registered data held until the master takes it.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (rd_en) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= addr_ok(ra) ? rd_val : 32'h0;
      s_axi_rresp  <= addr_ok(ra) ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  // Two-flop synchroniser for the asynchronous link status.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      link_meta <= '0;
      link_sync <= '0;
    end else begin
      link_meta <= link_up;
      link_sync <= link_meta;
    end
  end

`ifdef ETH_PORT_CTRL_LINK_IRQ_EN
  logic [NUM_PORTS-1:0] link_prev, link_chg_next;

  assign link_chg_next = (link_chg & ~chg_clr) | (link_sync ^ link_prev);

  // Sticky change flags; an edge in the clearing cycle keeps its bit set.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      link_prev <= '0;
      link_chg  <= '0;
      irq       <= 1'b0;
    end else begin
      link_prev <= link_sync;
      link_chg  <= link_chg_next;
      irq       <= |link_chg_next;
    end
  end
`else
  assign link_chg = '0;
  assign irq      = 1'b0;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    eth_port_rst_gen #(
      .RST_CNT_WIDTH (RST_CNT_WIDTH),
      .RST_DEF_CYCLES(RST_DEF_CYCLES)
    ) u_rst_gen (
      .clk    (aclk),
      .rst_n  (arstn),
      .trig   (trig[p]),
      .width  (rst_width),
      .reset_n(port_reset_n[p]),
      .busy   (busy[p])
    );
  end

endmodule
